// File: rtl/req_ack_stream_arbiter.sv
// Round-robin arbiter: four-phase req/ack clients onto one valid/ready stream.
// Optional send-wait timeout compiled in with `define RRA_TIMEOUT_EN.
module req_ack_stream_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, ACK, RELEASE} state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("req_ack_stream_arbiter: parameter out of legal range");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;
  logic                ack_min_q, ack_min_d;   // first ACK cycle already spent
  logic                dropped_q, dropped_d;   // requester let go during SEND

  logic [GW-1:0]       win;
  logic [DATA_W-1:0]   win_data;
  logic                win_found;

  // Round-robin scan starting just above the last grant.
  always_comb begin
    win       = grant_id_q;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [GW-1:0] cand;
      cand = GW'((int'(grant_id_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: every *_d gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    grant_id_d = grant_id_q;
    ack_min_d  = ack_min_q;
    dropped_d  = dropped_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = SEND;
          grant_id_d = win;
          out_data_d = win_data;
          dropped_d  = 1'b0;
        end
      end
      SEND: begin
        if (!req[grant_id_q]) dropped_d = 1'b1;
        if (out_ready) begin
          state_d   = ACK;
          ack_min_d = 1'b0;
        end
      end
      ACK: begin
        ack_min_d = 1'b1;
        // A requester that quit early gets exactly the two-cycle minimum.
        if (ack_min_q && (dropped_q || !req[grant_id_q])) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      grant_id_q <= GW'(NUM_REQ - 1);
      ack_min_q  <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      grant_id_q <= grant_id_d;
      ack_min_q  <= ack_min_d;
      dropped_q  <= dropped_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[grant_id_q] = 1'b1;
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

`ifdef RRA_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  // Pulse is registered so it lands in the cycle the counter reaches the limit.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = 1'b0;
    if (state_q == IDLE && win_found) begin
      wait_cnt_d = '0;
    end else if (state_q == SEND && !out_ready) begin
      if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
      timeout_err_d = (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_stream_arbiter.sv
// Directed self-checking bench for req_ack_stream_arbiter (default parameters).
module tb_req_ack_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  req_ack_stream_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   ack,       4'b0000);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"},  out_data,  8'h00);
    check({tag, "_gid"},   grant_id,  2'd3);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_tmo"},   timeout_err, 1'b0);
  endtask

  initial begin
    int grants[4];
    int gdata[4];
    int n_gr;
    int onehot_err;
    int gap_err;
    int tmo_pulses;
    int tmo_cycle;
    logic [3:0] prev_ack;

    // Reset values
    step();
    check_idle_outputs("rst");
    rst = 1'b0;

    // Single request, ready high
    req_data[7:0] = 8'h41;
    out_ready = 1'b1;
    req = 4'b0001;                                  // cycle 0
    check("s_c0_valid", out_valid, 1'b0);
    step();                                         // cycle 1
    check("s_c1_valid", out_valid, 1'b1);
    check("s_c1_data",  out_data,  8'h41);
    check("s_c1_ack",   ack,       4'b0000);
    step();                                         // cycle 2
    check("s_c2_ack",   ack,       4'b0001);
    check("s_c2_valid", out_valid, 1'b0);
    step();                                         // cycle 3
    check("s_c3_ack",   ack,       4'b0001);
    req = 4'b0000;
    step();                                         // cycle 4
    check("s_c4_ack",   ack,       4'b0000);
    check("s_c4_busy",  busy,      1'b1);
    step();
    step();                                         // cycle 6
    check("s_c6_busy",  busy,      1'b0);

    // Round-robin between requesters 0 and 2
    do_reset();
    req_data = 32'h44332211;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grants[i] = -1;
      gdata[i]  = -1;
    end
    n_gr = 0; onehot_err = 0; gap_err = 0;
    prev_ack = '0;
    req = 4'b0101;
    for (int cyc = 0; cyc < 60; cyc++) begin
      step();
      if ($countones(ack) > 1) onehot_err++;
      if (ack != 0 && prev_ack != 0 && ack != prev_ack) gap_err++;
      if (ack != 0 && prev_ack == 0 && n_gr < 4) begin
        for (int i = 0; i < 4; i++) if (ack[i]) grants[n_gr] = i;
        gdata[n_gr] = int'(out_data);
        n_gr++;
      end
      for (int i = 0; i < 4; i += 2) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = 1'b1;
      end
      prev_ack = ack;
    end
    check("rr_g0", grants[0], 0);
    check("rr_g1", grants[1], 2);
    check("rr_g2", grants[2], 0);
    check("rr_g3", grants[3], 2);
    check("rr_d0", gdata[0], 32'h11);
    check("rr_d1", gdata[1], 32'h33);
    check("rr_d2", gdata[2], 32'h11);
    check("rr_d3", gdata[3], 32'h33);
    check("rr_onehot", onehot_err, 0);
    check("rr_gap",    gap_err,    0);
    req = '0;

    // Backpressure: ready low for 5 SEND cycles
    do_reset();
    req_data = 32'h00005A00;
    req = 4'b0010;                                  // cycle 0
    for (int c = 1; c <= 5; c++) begin
      step();
      check("bp_valid", out_valid, 1'b1);
      check("bp_data",  out_data,  8'h5A);
      check("bp_ack",   ack,       4'b0000);
      check("bp_tmo",   timeout_err, 1'b0);
    end
    step();                                         // cycle 6
    check("bp_c6_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();                                         // cycle 7
    check("bp_c7_ack",   ack,       4'b0010);
    check("bp_c7_valid", out_valid, 1'b0);
    req = '0;
    step(); step(); step(); step();
    check("bp_idle", busy, 1'b0);

    // Long stall: timeout when compiled in, silent otherwise
    do_reset();
    req_data = 32'h00C30000;
    req = 4'b0100;                                  // cycle 0
    tmo_pulses = 0; tmo_cycle = -1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 16) out_ready = 1'b1;
      if (timeout_err) begin
        tmo_pulses++;
        tmo_cycle = c;
      end
      check("to_valid", out_valid, 1'b1);
    end
    step();                                         // cycle 17
    check("to_ack",  ack,      4'b0100);
    check("to_data", out_data, 8'hC3);
`ifdef RRA_TIMEOUT_EN
    check("to_pulses", tmo_pulses, 1);
    check("to_cycle",  tmo_cycle,  11);
`else
    check("to_pulses", tmo_pulses, 0);
`endif
    req = '0;
    step(); step(); step();

    // Asynchronous reset while out_valid is high
    do_reset();
    req_data = 32'h0000B200;
    req = 4'b0010;
    step();
    step();
    check("mr_valid_pre", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("mr");
    #3 rst = 1'b0;
    step();
    check("mr_valid_post", out_valid, 1'b1);
    check("mr_gid_post",   grant_id,  2'd1);
    check("mr_data_post",  out_data,  8'hB2);
    out_ready = 1'b1;
    step();
    check("mr_ack_post", ack, 4'b0010);
    req = '0;
    step(); step(); step();

    // Early request drop during SEND
    do_reset();
    req_data = 32'h7E000000;
    req = 4'b1000;                                  // cycle 0
    step();                                         // cycle 1
    check("ed_valid", out_valid, 1'b1);
    req = 4'b0000;
    step();                                         // cycle 2
    check("ed_c2_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();                                         // cycle 3
    check("ed_c3_ack", ack, 4'b1000);
    step();                                         // cycle 4
    check("ed_c4_ack", ack, 4'b1000);
    step();                                         // cycle 5
    check("ed_c5_ack",  ack,  4'b0000);
    check("ed_c5_busy", busy, 1'b1);
    step();                                         // cycle 6
    check("ed_c6_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
